// File: rtl/decode_pattern_matcher.sv
// decode_pattern_matcher
//
// Purpose:
//    Sequential mask/value matcher for the decode path. A programmable table of
//    ENTRIES (mask, value, valid) patterns is scanned one entry per cycle
//    against a captured instruction word. The lowest matching index (or a miss)
//    is returned over a valid/ready response port.
//
// Ports:
//    clk            - single clock, all state changes on posedge
//    reset          - synchronous, active-high; invalidates table, FSM to IDLE
//    wr_en          - table write strobe (legal in any state)
//    wr_idx         - entry index to write
//    wr_mask        - compare mask (1 = bit compared)
//    wr_value       - expected value
//    wr_entry_valid - valid bit to store (0 invalidates the entry)
//    req_valid      - request word present
//    req_ready      - matcher idle and able to accept a request
//    req_word       - instruction word to decode
//    rsp_valid      - response present
//    rsp_ready      - consumer accepts the response
//    rsp_hit        - 1 when some valid entry matched
//    rsp_idx        - lowest matching index (0 on miss)
//    rsp_word       - echo of the captured request word
module decode_pattern_matcher #(
   parameter int WIDTH   = 32,
   parameter int ENTRIES = 8,
   parameter int IDX_W   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_mask,
   input  logic [WIDTH-1:0] wr_value,
   input  logic             wr_entry_valid,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_word,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_hit,
   output logic [IDX_W-1:0] rsp_idx,
   output logic [WIDTH-1:0] rsp_word
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   // Pattern table. Mask/value carry no reset; only the valid bits are cleared.
   logic [WIDTH-1:0]   mask_mem  [ENTRIES];
   logic [WIDTH-1:0]   value_mem [ENTRIES];
   logic [ENTRIES-1:0] valid_reg;

   state_t             state_reg;
   logic [IDX_W-1:0]   scan_idx_reg;
   logic [WIDTH-1:0]   word_reg;
   logic               req_ready_reg;
   logic               rsp_valid_reg;
   logic               rsp_hit_reg;
   logic [IDX_W-1:0]   rsp_idx_reg;

   // Per-entry masked compare against the captured word. The scan reads the
   // registered table, so a write landing on the same edge as a compare only
   // affects later compares.
   logic [ENTRIES-1:0] match_vec;

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
         assign match_vec[gi] = valid_reg[gi] &&
            ((word_reg & mask_mem[gi]) == (value_mem[gi] & mask_mem[gi]));
      end
   endgenerate

   // Table contents: written in any FSM state.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mask_mem[wr_idx]  <= wr_mask;
         value_mem[wr_idx] <= wr_value;
      end
   end

   // Valid bits: reset wins over a coincident write so the table is always
   // empty after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg <= '0;
      end else if (wr_en) begin
         valid_reg[wr_idx] <= wr_entry_valid;
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         scan_idx_reg  <= '0;
         word_reg      <= '0;
         req_ready_reg <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rsp_hit_reg   <= 1'b0;
         rsp_idx_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  word_reg      <= req_word;
                  scan_idx_reg  <= '0;
                  req_ready_reg <= 1'b0;
                  state_reg     <= SCAN;
               end
            end
            SCAN: begin
               // Ascending scan that stops at the first hit gives
               // lowest-index priority.
               if (match_vec[scan_idx_reg]) begin
                  rsp_hit_reg   <= 1'b1;
                  rsp_idx_reg   <= scan_idx_reg;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end else if (scan_idx_reg == LAST_IDX) begin
                  rsp_hit_reg   <= 1'b0;
                  rsp_idx_reg   <= '0;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end else begin
                  scan_idx_reg <= scan_idx_reg + 1'b1;
               end
            end
            RESP: begin
               // Return through IDLE so a new request is accepted one cycle
               // after the response handshake at the earliest.
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  req_ready_reg <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg     <= IDLE;
               req_ready_reg <= 1'b1;
               rsp_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_hit   = rsp_hit_reg;
   assign rsp_idx   = rsp_idx_reg;
   assign rsp_word  = word_reg;

endmodule

// File: doc/decode_pattern_matcher.md
Name: decode_pattern_matcher

Overview:
- Sequential mask/value matcher for the ISA-independent decode path.
- Holds a programmable table of ENTRIES (mask, value) patterns and accepts instruction words over a valid/ready request port.
- Scans the table one entry per cycle, applying the masked equality compare the comparator unit implements, and returns the lowest matching entry index (or a miss) over a valid/ready response port.
- Is the consumer/reader of comparator results, where the comparator produces them.

Parameters:
- WIDTH, 32, instruction word, mask and value width.
- ENTRIES, 8, number of pattern table entries (power of two, at least 2).
- IDX_W, 3, index width; must equal $clog2(ENTRIES).

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  table write strobe.
- wr_idx  input  IDX_W  entry index to write.
- wr_mask  input  WIDTH  mask (1 = bit compared).
- wr_value  input  WIDTH  expected value.
- wr_entry_valid  input  1  entry valid bit to store (0 = invalidate).
- req_valid  input  1  request word present.
- req_ready  output  1  matcher can accept a request.
- req_word  input  WIDTH  instruction word to decode.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_hit  output  1  1 = some valid entry matched.
- rsp_idx  output  IDX_W  lowest matching index (0 on miss).
- rsp_word  output  WIDTH  echo of the captured request word.

Behaviour:
- Reset (synchronous, active-high):
  - All entry valid bits cleared; mask/value contents don't-care.
  - FSM goes to IDLE.
  - req_ready=1 in the cycle after reset deasserts; rsp_valid=0, rsp_hit=0, rsp_idx=0, rsp_word=0.
- Match rule: entry e matches when valid[e]=1 and (req_word & mask[e]) == (value[e] & mask[e]).
  - Value bits outside the mask are ignored.
  - mask=0 on a valid entry matches every word.
- Table writes:
  - When wr_en=1 at a posedge, entry wr_idx is loaded with mask, value and valid. This is legal in any FSM state.
  - The scan compares registered table contents. A write to the entry being compared in the same cycle affects only later compares.
  - A write during a scan to an entry not yet compared is seen by that scan.
- FSM states: IDLE, SCAN, RESP.
  - IDLE: req_ready=1, rsp_valid=0. On req_valid=1 at a posedge (accept edge T0): capture req_word, set scan index to 0, go to SCAN.
  - SCAN: req_ready=0. Each cycle compares the entry at the scan index.
    - On match: latch rsp_hit=1 and rsp_idx=index, go to RESP.
    - No match and index=ENTRIES-1: rsp_hit=0, rsp_idx=0, go to RESP.
    - Otherwise: increment index.
  - RESP: rsp_valid=1; rsp_hit, rsp_idx and rsp_word are held stable. On rsp_ready=1 at a posedge, go to IDLE. rsp_valid drops the next cycle.
- Latency:
  - A hit at entry k gives rsp_valid high from edge T0+k+1.
  - A miss gives rsp_valid high from edge T0+ENTRIES.
  - With rsp_ready held high, a new request is accepted no earlier than 1 cycle after the response handshake, because IDLE is re-entered first.
- Priority: the lowest index wins because the scan is ascending and stops at the first hit.
- Boundary conditions:
  - Empty table (no valid entries): always a miss after ENTRIES cycles.
  - Scan index never wraps: the terminal compare is at ENTRIES-1.
  - req_valid held high while busy is ignored; the word is not captured until IDLE.
  - rsp_ready held low: stays in RESP indefinitely with outputs stable.
  - Reset mid-SCAN or in RESP: the pending response is discarded, and the table is invalidated on the same edge.
- Widths: all compares are full WIDTH with no truncation. rsp_idx is IDX_W bits.

Test Plan:
- Reset, then request req_word=32'h0000_0013 on an empty table -> rsp_valid at T0+8, rsp_hit=0, rsp_idx=0, rsp_word=32'h0000_0013.
- Program entry 2 with mask=32'h0000_007F, value=32'h0000_0013, valid=1; request 32'hABCD_0013 -> rsp_valid at T0+3, rsp_hit=1, rsp_idx=2.
- Program entries 1 and 5 with identical patterns (mask=32'hFFFF_FFFF, value=32'h1234_5678); request 32'h1234_5678 -> rsp_idx=1. Invalidate entry 1 (wr_entry_valid=0) and repeat -> rsp_idx=5 at T0+6.
- Entry 7 with mask=0, valid=1, all others invalid; request 32'hFFFF_FFFF -> hit, rsp_idx=7, latency 8 cycles. Hold rsp_ready=0 for 4 cycles -> outputs stable and req_ready=0 throughout.
- Assert reset during the SCAN cycle comparing entry 3 -> next cycle rsp_valid=0 and req_ready=1; a following request with the previously matching word -> miss, because the table was invalidated.
- Back-to-back: req_valid and rsp_ready held high with 3 distinct words -> 3 responses in order, each rsp_word matching its request, with one IDLE cycle between a response handshake and the next accept.
